// File: rtl/text_framer.sv
// Buffers PAYLOAD_LEN text bytes, then streams preamble, SOF, length, payload and checksum.
// Define TEXT_FRAMER_CRC8_EN to replace the additive checksum with CRC-8 (poly 0x07).
module text_framer #(
  parameter int          PAYLOAD_LEN   = 16,
  parameter int          PREAMBLE_LEN  = 4,
  parameter logic [7:0]  PREAMBLE_BYTE = 8'h55,
  parameter logic [7:0]  SOF_BYTE      = 8'h7E
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic [7:0] frame_out,
  output logic       frame_valid,
  input  logic       frame_ready,
  output logic       frame_start,
  output logic       frame_end,
  output logic       busy
);

  localparam int ADDR_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam int PRE_W  = (PREAMBLE_LEN > 1) ? $clog2(PREAMBLE_LEN) : 1;
  localparam logic [ADDR_W-1:0] PAY_LAST = ADDR_W'(PAYLOAD_LEN - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PREAMBLE_LEN - 1);
  localparam logic [7:0]        LEN_BYTE = 8'(PAYLOAD_LEN);

  typedef enum logic [2:0] {ST_FILL, ST_PRE, ST_SOF, ST_LEN, ST_PAY, ST_CHK} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [PRE_W-1:0]  pre_reg, pre_next;
  logic [7:0]        acc_reg, acc_next;
  logic [7:0]        frame_out_reg, frame_out_next;
  logic              frame_valid_reg, frame_valid_next;
  logic              frame_start_reg, frame_start_next;
  logic              frame_end_reg, frame_end_next;

  logic              wr_en;
  logic              out_xfer;
  logic [ADDR_W-1:0] addr_inc;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        acc_upd;
  logic [7:0]        chk_byte;
  logic [7:0]        mem [0:(1<<ADDR_W)-1];

  assign out_xfer = frame_valid_reg && frame_ready;
  assign addr_inc = addr_reg + ADDR_W'(1);
  // The read address is one byte ahead so the payload byte lands in frame_out on the transfer edge.
  assign rd_addr  = (state_reg == ST_PAY) ? addr_inc : '0;
  assign rd_data  = mem[rd_addr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr_reg] <= data_in;
    end
  end

`ifdef TEXT_FRAMER_CRC8_EN
  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] x;
    x = crc ^ d;
    for (int i = 0; i < 8; i++) begin
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h07) : {x[6:0], 1'b0};
    end
    return x;
  endfunction

  assign acc_upd  = crc8_byte(acc_reg, data_in);
  assign chk_byte = acc_reg;
`else
  assign acc_upd  = acc_reg + data_in;
  assign chk_byte = 8'(~acc_reg + 8'd1);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= ST_FILL;
      addr_reg        <= '0;
      pre_reg         <= '0;
      acc_reg         <= 8'h00;
      frame_out_reg   <= 8'h00;
      frame_valid_reg <= 1'b0;
      frame_start_reg <= 1'b0;
      frame_end_reg   <= 1'b0;
    end else begin
      state_reg       <= state_next;
      addr_reg        <= addr_next;
      pre_reg         <= pre_next;
      acc_reg         <= acc_next;
      frame_out_reg   <= frame_out_next;
      frame_valid_reg <= frame_valid_next;
      frame_start_reg <= frame_start_next;
      frame_end_reg   <= frame_end_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    addr_next        = addr_reg;
    pre_next         = pre_reg;
    acc_next         = acc_reg;
    frame_out_next   = frame_out_reg;
    frame_valid_next = frame_valid_reg;
    frame_start_next = frame_start_reg;
    frame_end_next   = frame_end_reg;
    wr_en            = 1'b0;
    case (state_reg)
      ST_FILL: begin
        if (data_in_valid) begin
          wr_en    = 1'b1;
          acc_next = acc_upd;
          if (addr_reg == PAY_LAST) begin
            state_next       = ST_PRE;
            addr_next        = '0;
            pre_next         = '0;
            frame_out_next   = PREAMBLE_BYTE;
            frame_valid_next = 1'b1;
            frame_start_next = 1'b1;
          end else begin
            addr_next = addr_inc;
          end
        end
      end
      ST_PRE: begin
        if (out_xfer) begin
          frame_start_next = 1'b0;
          if (pre_reg == PRE_LAST) begin
            state_next     = ST_SOF;
            frame_out_next = SOF_BYTE;
          end else begin
            pre_next = pre_reg + PRE_W'(1);
          end
        end
      end
      ST_SOF: begin
        if (out_xfer) begin
          state_next     = ST_LEN;
          frame_out_next = LEN_BYTE;
        end
      end
      ST_LEN: begin
        if (out_xfer) begin
          state_next     = ST_PAY;
          addr_next      = '0;
          frame_out_next = rd_data;
        end
      end
      ST_PAY: begin
        if (out_xfer) begin
          if (addr_reg == PAY_LAST) begin
            state_next     = ST_CHK;
            frame_out_next = chk_byte;
            frame_end_next = 1'b1;
          end else begin
            addr_next      = addr_inc;
            frame_out_next = rd_data;
          end
        end
      end
      ST_CHK: begin
        if (out_xfer) begin
          state_next       = ST_FILL;
          addr_next        = '0;
          acc_next         = 8'h00;
          frame_out_next   = 8'h00;
          frame_valid_next = 1'b0;
          frame_end_next   = 1'b0;
        end
      end
      default: begin
        state_next = ST_FILL;
      end
    endcase
  end

  always_comb begin
    data_in_ready = (state_reg == ST_FILL);
    busy          = (state_reg != ST_FILL);
    frame_out     = frame_out_reg;
    frame_valid   = frame_valid_reg;
    frame_start   = frame_start_reg;
    frame_end     = frame_end_reg;
  end

endmodule
